// File: rtl/cordic_sched_pkg.sv
// Shared definitions for the CORDIC operation scheduler: func codes, legality
// check, FSM state encoding and the default iteration latency.
package cordic_sched_pkg;

  localparam logic [3:0] FUNC_EXP     = 4'h0;
  localparam logic [3:0] FUNC_SINH    = 4'h1;
  localparam logic [3:0] FUNC_COSH    = 4'h2;
  localparam logic [3:0] FUNC_TANH    = 4'h3;
  localparam logic [3:0] FUNC_LN      = 4'h4;
  localparam logic [3:0] FUNC_SQRT    = 4'h5;
  localparam logic [3:0] FUNC_ARCTANH = 4'h7;
  localparam logic [3:0] FUNC_IDLE    = 4'hF;

  localparam int DEFAULT_LAT = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic logic is_legal_func(input logic [3:0] f);
    case (f)
      FUNC_EXP, FUNC_SINH, FUNC_COSH, FUNC_TANH,
      FUNC_LN, FUNC_SQRT, FUNC_ARCTANH: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or above rr_ptr_i,
// wrapping, reported as a one-hot grant and an encoded index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  rr_ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_i) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = ID_W'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/cordic_op_scheduler.sv
// Round-robin scheduler sharing one bank of CORDIC units over a common result bus.
// Optional per-requester completed-op counters: define CORDIC_SCHED_STATS_EN.
module cordic_op_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int LAT    = DEFAULT_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [4*N_REQ-1:0]        req_func,
  input  logic [DATA_W*N_REQ-1:0]   req_x,
  input  logic [DATA_W*N_REQ-1:0]   req_y,
  output logic [N_REQ-1:0]          gnt,
  output logic                      resp_valid,
  output logic [$clog2(N_REQ)-1:0]  resp_id,
  output logic [RES_W-1:0]          resp_data,
  output logic                      resp_err,
  output logic                      st,
  output logic [3:0]                func,
  output logic [DATA_W-1:0]         x_1,
  output logic [DATA_W-1:0]         y_1,
  input  logic [RES_W-1:0]          result
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [16*N_REQ-1:0]       op_count
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LAT + 1);

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q, op_id_q, resp_id_q;
  logic                op_legal_q, gnt_st_q, resp_valid_q, resp_err_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [3:0]          func_q;
  logic [DATA_W-1:0]   x_q, y_q;
  logic [RES_W-1:0]    resp_data_q;

  logic [N_REQ-1:0]    arb_gnt;
  logic [ID_W-1:0]     arb_id;
  logic                arb_valid;
  logic [3:0]          sel_func;
  logic [DATA_W-1:0]   sel_x, sel_y;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .en_i     (state_q == S_IDLE),
    .gnt_o    (arb_gnt),
    .id_o     (arb_id),
    .valid_o  (arb_valid)
  );

  assign sel_func = req_func[int'(arb_id)*4 +: 4];
  assign sel_x    = req_x[int'(arb_id)*DATA_W +: DATA_W];
  assign sel_y    = req_y[int'(arb_id)*DATA_W +: DATA_W];

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] op_cnt_q [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_op_count
    assign op_count[g*16 +: 16] = op_cnt_q[g];
  end
`endif

  // Outputs are registered one cycle ahead so gnt/st/func line up with LAUNCH.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      op_id_q      <= '0;
      op_legal_q   <= 1'b0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      gnt_st_q     <= 1'b0;
      func_q       <= FUNC_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
`ifdef CORDIC_SCHED_STATS_EN
      for (int i = 0; i < N_REQ; i++) op_cnt_q[i] <= '0;
`endif
    end else begin
      gnt_q        <= '0;
      gnt_st_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_valid) begin
            op_id_q    <= arb_id;
            op_legal_q <= is_legal_func(sel_func);
            gnt_q      <= arb_gnt;
            state_q    <= S_LAUNCH;
            if (is_legal_func(sel_func)) begin
              gnt_st_q <= 1'b1;
              func_q   <= sel_func;
              x_q      <= sel_x;
              y_q      <= sel_y;
            end
          end
        end
        S_LAUNCH: begin
          rr_ptr_q <= (op_id_q == ID_W'(N_REQ - 1)) ? '0 : op_id_q + ID_W'(1);
          if (op_legal_q) begin
            cnt_q   <= CNT_W'(1);
            state_q <= S_WAIT;
          end else begin
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
            resp_id_q    <= op_id_q;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LAT)) begin
            resp_data_q  <= result;
            resp_err_q   <= 1'b0;
            resp_id_q    <= op_id_q;
            resp_valid_q <= 1'b1;
            func_q       <= FUNC_IDLE;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
`ifdef CORDIC_SCHED_STATS_EN
          if (!resp_err_q && op_cnt_q[op_id_q] != 16'hFFFF)
            op_cnt_q[op_id_q] <= op_cnt_q[op_id_q] + 16'd1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign st         = gnt_st_q;
  assign func       = func_q;
  assign x_1        = x_q;
  assign y_1        = y_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_cordic_op_scheduler.sv
// Directed self-checking bench for cordic_op_scheduler with a one-unit result-bus model.
// Exercises op_count as well when CORDIC_SCHED_STATS_EN is defined.
module tb_cordic_op_scheduler;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int RW  = 32;
  localparam int LAT = 17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [4*N-1:0]    req_func = '0;
  logic [DW*N-1:0]   req_x = '0;
  logic [DW*N-1:0]   req_y = '0;
  logic [N-1:0]      gnt;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [RW-1:0]     resp_data;
  logic              resp_err;
  logic              st;
  logic [3:0]        func;
  logic [DW-1:0]     x_1, y_1;
  logic [RW-1:0]     result;
`ifdef CORDIC_SCHED_STATS_EN
  logic [16*N-1:0]   op_count;
`endif

  cordic_op_scheduler #(.N_REQ(N), .DATA_W(DW), .RES_W(RW), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_func   (req_func),
    .req_x      (req_x),
    .req_y      (req_y),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .st         (st),
    .func       (func),
    .x_1        (x_1),
    .y_1        (y_1),
    .result     (result)
`ifdef CORDIC_SCHED_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          st_cnt = 0;
  int          u_start = 0;
  logic        u_busy = 1'b0;
  logic [31:0] unit_val = 32'h0;

  // Function-unit model: result becomes valid LAT cycles after the st cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (st) begin
      st_cnt  <= st_cnt + 1;
      u_start <= cyc;
      u_busy  <= 1'b1;
    end
  end
  assign result = (u_busy && cyc >= u_start + LAT) ? unit_val : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
    req_func[id*4 +: 4] = f;
    req_x[id*DW +: DW]  = x;
    req_y[id*DW +: DW]  = y;
    req[id]             = 1'b1;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int gc);
    g  = '0;
    gc = 0;
    for (int n = 0; n < 200 && g == '0; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g  = gnt;
        gc = cyc;
      end
    end
    if (g == '0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gnt_timeout: no grant within 200 cycles");
    end
  endtask

  task automatic wait_resp(output int rc);
    logic seen;
    seen = 1'b0;
    rc   = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        rc   = cyc;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout: no resp_valid within 200 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_gnt"},        32'(gnt),        32'h0);
    check({pfx, "_st"},         32'(st),         32'h0);
    check({pfx, "_func"},       32'(func),       32'hF);
    check({pfx, "_x1"},         32'(x_1),        32'h0);
    check({pfx, "_y1"},         32'(y_1),        32'h0);
    check({pfx, "_resp_valid"}, 32'(resp_valid), 32'h0);
    check({pfx, "_resp_id"},    32'(resp_id),    32'h0);
    check({pfx, "_resp_data"},  resp_data,       32'h0);
    check({pfx, "_resp_err"},   32'(resp_err),   32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef CORDIC_SCHED_STATS_EN
  task automatic run_op(input int id, input logic [3:0] f);
    logic [N-1:0] g;
    int           gc, rc;
    set_req(id, f, 16'h0100, 16'h0200);
    wait_gnt(g, gc);
    req[id] = 1'b0;
    wait_resp(rc);
    @(negedge clk);
  endtask
`endif

  initial begin
    logic [N-1:0] g;
    int           gc, rc, s0, bad, prev;
    int           rr_exp [4] = '{1, 3, 1, 3};

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Single legal op from requester 0
    unit_val = 32'h0000_1234;
    s0 = st_cnt;
    set_req(0, 4'h7, 16'h4000, 16'h1000);
    wait_gnt(g, gc);
    check("t1_gnt",  32'(g),   32'h1);
    check("t1_st",   32'(st),  32'h1);
    check("t1_func", 32'(func), 32'h7);
    check("t1_x1",   32'(x_1), 32'h4000);
    check("t1_y1",   32'(y_1), 32'h1000);
    req[0] = 1'b0;
    bad = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (func !== 4'h7 || resp_valid !== 1'b0) bad++;
    end
    check("t1_hold_bad_cycles", 32'(bad), 32'h0);
    @(negedge clk);
    check("t1_latency",   32'(cyc - gc),   32'd18);
    check("t1_resp_vld",  32'(resp_valid), 32'h1);
    check("t1_resp_id",   32'(resp_id),    32'h0);
    check("t1_resp_data", resp_data,       32'h0000_1234);
    check("t1_resp_err",  32'(resp_err),   32'h0);
    check("t1_func_idle", 32'(func),       32'hF);
    check("t1_st_pulses", 32'(st_cnt - s0), 32'h1);
    @(negedge clk);
    check("t1_vld_drop",  32'(resp_valid), 32'h0);
    check("t1_data_hold", resp_data,       32'h0000_1234);

    // Round-robin with requesters 1 and 3 held from reset
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    set_req(1, 4'h1, 16'h0011, 16'h0022);
    set_req(3, 4'h2, 16'h0033, 16'h0044);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    unit_val = 32'hCAFE_0001;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, gc);
      check("rr_gnt", 32'(g), 32'(1) << rr_exp[i]);
      if (i > 0) check("rr_spacing", 32'(gc - prev), 32'd20);
      prev = gc;
      wait_resp(rc);
      check("rr_resp_id",  32'(resp_id), 32'(rr_exp[i]));
      check("rr_latency",  32'(rc - gc), 32'd18);
    end
    req = '0;

    // Illegal func from requester 2
    s0 = st_cnt;
    set_req(2, 4'hF, 16'h7777, 16'h8888);
    wait_gnt(g, gc);
    check("ill_gnt", 32'(g),  32'h4);
    check("ill_st",  32'(st), 32'h0);
    req[2] = 1'b0;
    @(negedge clk);
    check("ill_resp_vld",  32'(resp_valid), 32'h1);
    check("ill_resp_err",  32'(resp_err),   32'h1);
    check("ill_resp_data", resp_data,       32'h0);
    check("ill_resp_id",   32'(resp_id),    32'h2);
    check("ill_st_pulses", 32'(st_cnt - s0), 32'h0);

    // Reset in the middle of WAIT (cnt==8)
    unit_val = 32'h5555_AAAA;
    set_req(0, 4'h7, 16'h1357, 16'h2468);
    wait_gnt(g, gc);
    req[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid");
    rst_n = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad++;
    end
    check("mid_no_resp", 32'(bad), 32'h0);
    set_req(0, 4'h1, 16'h0101, 16'h0202);
    set_req(2, 4'h2, 16'h0303, 16'h0404);
    wait_gnt(g, gc);
    check("mid_ptr_gnt", 32'(g), 32'h1);
    req[0] = 1'b0;
    wait_resp(rc);
    check("mid_resp_id",   32'(resp_id),  32'h0);
    check("mid_resp_err",  32'(resp_err), 32'h0);
    check("mid_resp_data", resp_data,     32'h5555_AAAA);
    wait_gnt(g, gc);
    check("mid_gnt2", 32'(g), 32'h4);
    req[2] = 1'b0;
    wait_resp(rc);
    check("mid_resp_id2", 32'(resp_id), 32'h2);

    // Operand stability after grant
    unit_val = 32'h0BAD_F00D;
    set_req(3, 4'h5, 16'h1111, 16'h2222);
    wait_gnt(g, gc);
    check("stab_x1_at_gnt", 32'(x_1), 32'h1111);
    req[3] = 1'b0;
    req_x[3*DW +: DW] = 16'hFFFF;
    req_y[3*DW +: DW] = 16'hEEEE;
    bad = 0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (x_1 !== 16'h1111 || y_1 !== 16'h2222) bad++;
    end
    check("stab_bad_cycles", 32'(bad), 32'h0);
    wait_resp(rc);
    check("stab_resp_data", resp_data, 32'h0BAD_F00D);
    check("stab_resp_id",   32'(resp_id), 32'h3);

`ifdef CORDIC_SCHED_STATS_EN
    do_reset();
    check("stats_after_reset", 32'(op_count[15:0]), 32'h0);
    for (int i = 0; i < 3; i++) run_op(0, 4'h0);
    run_op(1, 4'hF);
    check("stats_req0", 32'(op_count[15:0]),  32'd3);
    check("stats_req1", 32'(op_count[31:16]), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
